note_play_sequencer: RTL and testbench

Sequences the 4-bit note code and 7-bit LED bus that feed the tone generator and key LEDs. In free-play mode it forwards the decoded key note (0..7) from the key decoder. In auto-play mode it steps through an internal 16-entry song table, holding each note for a programmed number of beats with a silent articulation gap between notes. It sits between the key decoder and the tone generator and owns arbitration of that shared note path.

---
 rtl/note_play_sequencer.sv | 118 +++++++++++
 tb/tb_note_play_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/note_play_sequencer.sv
// note_play_sequencer: arbitrates the note path between key input and a hard-wired song player.
// Optional LEARN_MODE_EN: holds each song note until the matching key is pressed.
module note_play_sequencer #(
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_note,
  input  logic       auto_mode,
  input  logic       start,
  input  logic       learn_mode,
  output logic [3:0] note_out,
  output logic [6:0] led_out,
  output logic       playing,
  output logic       song_done
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_e;
  // {note[3:0], beats[2:0]}, beats=0 ends the song
  localparam logic [6:0] SONG [16] = '{
    7'h09, 7'h09, 7'h29, 7'h29, 7'h31, 7'h31, 7'h2A, 7'h21,
    7'h21, 7'h19, 7'h19, 7'h11, 7'h11, 7'h0A, 7'h00, 7'h00
  };
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d, note_q, note_d, key_f;
  logic [31:0] cnt_q, cnt_d, lim;
  logic [6:0]  led_q, led_d, ent, nxt;
  logic [7:0]  led_sh;
  logic        learn;
`ifdef LEARN_MODE_EN
  assign learn = learn_mode;
`else
  logic unused_learn;
  assign unused_learn = learn_mode;
  assign learn = 1'b0;
`endif
  always_comb begin
    ent     = SONG[idx_q];
    nxt     = SONG[idx_q + 4'd1];
    key_f   = key_note[3] ? 4'd0 : key_note;
    lim     = 32'(ent[2:0]) * 32'(BEAT_CYCLES);
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 32'd1;
    note_d  = 4'd0;
    case (state_q)
      IDLE: begin
        note_d = key_f;
        cnt_d  = 32'd0;
        if (start && auto_mode) begin
          state_d = PLAY;
          idx_d   = 4'd0;
          note_d  = SONG[0][6:3];
        end
      end
      PLAY: begin
        note_d = ent[6:3];
        if (learn) begin
          cnt_d = 32'd0;
          if (key_note == ent[6:3]) begin
            state_d = GAP;
            note_d  = 4'd0;
          end
        end else if (cnt_q == lim - 32'd1) begin
          state_d = GAP;
          note_d  = 4'd0;
          cnt_d   = 32'd0;
        end
      end
      GAP: begin
        if (cnt_q == 32'(GAP_CYCLES - 1)) begin
          cnt_d = 32'd0;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15 || nxt[2:0] == 3'd0) begin
            state_d = DONE;
            idx_d   = 4'd0;
          end else begin
            state_d = PLAY;
            note_d  = nxt[6:3];
          end
        end
      end
      default: begin
        state_d = IDLE;
        note_d  = key_f;
        cnt_d   = 32'd0;
      end
    endcase
    // losing auto_mode mid-song returns the path to the keys, silently
    if ((state_q == PLAY || state_q == GAP) && !auto_mode) begin
      state_d = IDLE;
      idx_d   = 4'd0;
      cnt_d   = 32'd0;
      note_d  = 4'd0;
    end
    led_sh = 8'd1 << note_d;
    led_d  = led_sh[7:1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 32'd0;
      note_q  <= 4'd0;
      led_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      led_q   <= led_d;
    end
  end
  assign note_out  = note_q;
  assign led_out   = led_q;
  assign playing   = (state_q == PLAY) || (state_q == GAP);
  assign song_done = (state_q == DONE);
endmodule

// File: tb/tb_note_play_sequencer.sv
// tb_note_play_sequencer: random stimulus against a per-cycle song schedule model.
module tb_note_play_sequencer;
  localparam int BEAT = 4;
  localparam int GAPC = 2;
  logic       clk = 1'b0;
  logic       rst, auto_mode, start, learn_mode;
  logic [3:0] key_note, note_out;
  logic [6:0] led_out;
  logic       playing, song_done;
  int n_cmp = 0;
  int n_err = 0;
  int song_n [16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
  int song_b [16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 0, 0};
  logic [5:0] q [$];
  logic [5:0] cur;
  bit act;
  int ons, dones;
  bit prev_on;

  note_play_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .key_note(key_note), .auto_mode(auto_mode), .start(start),
    .learn_mode(learn_mode), .note_out(note_out), .led_out(led_out), .playing(playing),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // expected record = {note[3:0], playing, song_done}, one per cycle
  task automatic build_song();
    q.delete();
    for (int i = 0; i < 16; i++) begin
      if (song_b[i] == 0) break;
      repeat (song_b[i] * BEAT) q.push_back({4'(song_n[i]), 2'b10});
      repeat (GAPC) q.push_back(6'b000010);
    end
    q.push_back(6'b000001);
  endtask

  task automatic model_edge();
    logic [3:0] kf;
    kf = (key_note > 4'd7) ? 4'd0 : key_note;
    if (rst) begin
      act = 0; q.delete(); cur = 6'd0;
    end else if (act && cur[1] && !auto_mode) begin
      act = 0; q.delete(); cur = 6'd0;
    end else if (act && q.size() > 0) begin
      cur = q.pop_front();
    end else if (!act && start && auto_mode) begin
      build_song(); act = 1; cur = q.pop_front();
    end else begin
      act = 0; cur = {kf, 2'b00};
    end
  endtask

  task automatic step(input logic r, input logic a, input logic s, input logic l, input logic [3:0] k);
    int en;
    rst = r; auto_mode = a; start = s; learn_mode = l; key_note = k;
    model_edge();
    @(negedge clk);
    en = int'(cur[5:2]);
    check("note_out", int'(note_out), en);
    check("led_out", int'(led_out), en == 0 ? 0 : (1 << (en - 1)));
    check("playing", int'(playing), int'(cur[1]));
    check("song_done", int'(song_done), int'(cur[0]));
    if (song_done) dones++;
    if (playing && note_out != 4'd0 && !prev_on) ons++;
    prev_on = playing && note_out != 4'd0;
  endtask

  initial begin
    act = 0; cur = 6'd0;
    // reset and key forwarding
    step(1, 0, 0, 0, 4'd3);
    step(1, 0, 0, 0, 4'd3);
    step(0, 0, 0, 0, 4'd3);
    check("key3_note", int'(note_out), 3);
    check("key3_led", int'(led_out), 7'b0000100);
    step(0, 0, 0, 0, 4'd9);
    check("key9_note", int'(note_out), 0);
    step(0, 0, 1, 0, 4'd5);
    step(0, 0, 0, 0, 4'd0);
    check("start_no_auto", int'(playing), 0);
    // full uninterrupted song, random keys/learn/extra starts ignored
    ons = 0; dones = 0; prev_on = 0;
    step(0, 1, 1, 0, 4'd0);
    check("first_note", int'(note_out), 1);
    for (int c = 2; c <= 93; c++) step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
    check("done_cycle93", int'(song_done), 1);
    step(0, 1, 0, 0, 4'd0);
    check("idle_cycle94", int'(playing), 0);
    check("note_ons", ons, 14);
    check("done_pulses", dones, 1);
    // abort during third note with key 6
    step(0, 1, 1, 0, 4'd6);
    repeat (2 * (BEAT + GAPC) + 1) step(0, 1, 0, 0, 4'd6);
    check("third_note", int'(note_out), 5);
    step(0, 0, 0, 0, 4'd6);
    check("abort_idle", int'(playing), 0);
    step(0, 0, 0, 0, 4'd6);
    check("abort_key", int'(note_out), 6);
    step(0, 1, 1, 0, 4'd0);
    check("replay_entry0", int'(note_out), 1);
    // random soak
    for (int c = 0; c < 4000; c++)
      step(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 199) != 0),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 4'($urandom));
    step(1, 1, 1, 0, 4'd4);
    check("final_rst_note", int'(note_out), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
